// File: rtl/arit_pkg.sv
// Shared constants and helpers for the accumulator datapath arithmetic unit.
package arit_pkg;

  localparam int unsigned DFLT_NB_DATA = 16;
  localparam int unsigned DFLT_NB_OP   = 5;

  localparam logic [DFLT_NB_OP-1:0] OP_ADD  = 5'b00100;
  localparam logic [DFLT_NB_OP-1:0] OP_ADDI = 5'b00101;
  localparam logic [DFLT_NB_OP-1:0] OP_SUB  = 5'b00110;
  localparam logic [DFLT_NB_OP-1:0] OP_SUBI = 5'b00111;

  // Bit 1 separates the subtract pair from the add pair among legal opcodes.
  function automatic logic is_sub(input logic [DFLT_NB_OP-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/arit_addsub.sv
// Combinational adder/subtractor with unsigned carry/borrow and signed overflow.
module arit_addsub #(
  parameter int unsigned NB_DATA = 16
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic               sub,
  output logic [NB_DATA-1:0] sum,
  output logic               carry,
  output logic               ovf
);

  logic [NB_DATA:0]   full;
  logic [NB_DATA-1:0] b_eff;
  logic               a_msb;
  logic               b_msb;
  logic               s_msb;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{NB_DATA{1'b0}}, sub};
    sum   = full[NB_DATA-1:0];
    a_msb = a[NB_DATA-1];
    b_msb = b[NB_DATA-1];
    s_msb = full[NB_DATA-1];
    // For subtraction the raw carry-out means "no borrow", so invert it.
    carry = sub ? ~full[NB_DATA] : full[NB_DATA];
    if (sub) begin
      ovf = (a_msb != b_msb) && (s_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) && (s_msb != a_msb);
    end
  end

endmodule

// File: rtl/arit_unit.sv
// Arithmetic unit: opcode decode, add/sub, and one registered result/flag stage.
module arit_unit
  import arit_pkg::*;
#(
  parameter int unsigned NB_DATA = DFLT_NB_DATA,
  parameter int unsigned NB_OP   = DFLT_NB_OP
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_ACC,
  input  logic [NB_DATA-1:0] i_DATA,
  input  logic [NB_OP-1:0]   i_OP,
  output logic [NB_DATA-1:0] o_RES,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_neg,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_illegal
);

  logic               legal;
  logic               sub;
  logic [NB_DATA-1:0] sum;
  logic               carry;
  logic               ovf;

  logic [NB_DATA-1:0] res_d, res_q;
  logic               valid_d, valid_q;
  logic               zero_d, zero_q;
  logic               neg_d, neg_q;
  logic               carry_d, carry_q;
  logic               ovf_d, ovf_q;
  logic               illegal_d, illegal_q;

  always_comb begin
    legal = (i_OP == OP_ADD) || (i_OP == OP_ADDI) || (i_OP == OP_SUB) || (i_OP == OP_SUBI);
    sub   = is_sub(i_OP);
  end

  arit_addsub #(
    .NB_DATA(NB_DATA)
  ) u_addsub (
    .a    (i_ACC),
    .b    (i_DATA),
    .sub  (sub),
    .sum  (sum),
    .carry(carry),
    .ovf  (ovf)
  );

  // Illegal ops only raise the illegal flag; result and arithmetic flags hold.
  always_comb begin
    res_d     = res_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    valid_d   = i_valid;
    if (i_valid) begin
      if (legal) begin
        res_d     = sum;
        zero_d    = (sum == '0);
        neg_d     = sum[NB_DATA-1];
        carry_d   = carry;
        ovf_d     = ovf;
        illegal_d = 1'b0;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      res_q     <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_RES     = res_q;
  assign o_valid   = valid_q;
  assign o_zero    = zero_q;
  assign o_neg     = neg_q;
  assign o_carry   = carry_q;
  assign o_ovf     = ovf_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_arit_unit.sv
// Bench for arit_unit: directed vector table, reset/back-to-back sequences, random vs model.
module tb_arit_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [15:0] i_ACC;
  logic [15:0] i_DATA;
  logic [4:0]  i_OP;
  logic [15:0] o_RES;
  logic        o_valid, o_zero, o_neg, o_carry, o_ovf, o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [15:0] m_res;
  logic        m_valid, m_zero, m_neg, m_carry, m_ovf, m_illegal;

  arit_unit dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_ACC    (i_ACC),
    .i_DATA   (i_DATA),
    .i_OP     (i_OP),
    .o_RES    (o_RES),
    .o_valid  (o_valid),
    .o_zero   (o_zero),
    .o_neg    (o_neg),
    .o_carry  (o_carry),
    .o_ovf    (o_ovf),
    .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic [15:0] acc;
    logic [15:0] data;
    logic [4:0]  op;
    logic        e_valid;
    logic [15:0] e_res;
    logic        e_zero, e_neg, e_carry, e_ovf, e_illegal;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model from plain integer arithmetic.
  task automatic model_step(input logic rst, input logic v, input logic [15:0] a,
                            input logic [15:0] d, input logic [4:0] op);
    int unsigned ua, ud, ur;
    int          sa, sd, sr;
    bit          legal, is_s;
    if (rst) begin
      m_res = 16'h0; m_valid = 0; m_zero = 0; m_neg = 0;
      m_carry = 0; m_ovf = 0; m_illegal = 0;
      return;
    end
    m_valid = v;
    if (!v) return;
    legal = (op >= 5'd4) && (op <= 5'd7);
    if (!legal) begin
      m_illegal = 1;
      return;
    end
    is_s = (op == 5'd6) || (op == 5'd7);
    ua = a; ud = d;
    sa = int'($signed(a)); sd = int'($signed(d));
    if (is_s) begin
      ur = (ua + 65536 - ud) % 65536;
      m_carry = (ua < ud);
      sr = sa - sd;
    end else begin
      ur = (ua + ud) % 65536;
      m_carry = (ua + ud) > 65535;
      sr = sa + sd;
    end
    m_ovf     = (sr > 32767) || (sr < -32768);
    m_res     = ur[15:0];
    m_zero    = (ur == 0);
    m_neg     = (ur >= 32768);
    m_illegal = 0;
  endtask

  task automatic apply(input logic rst, input logic v, input logic [15:0] a,
                       input logic [15:0] d, input logic [4:0] op);
    i_reset = rst; i_valid = v; i_ACC = a; i_DATA = d; i_OP = op;
    @(posedge i_clk);
    #1;
    model_step(rst, v, a, d, op);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},   {31'b0, o_valid},   {31'b0, m_valid});
    chk({tag, ".res"},     {16'b0, o_RES},     {16'b0, m_res});
    chk({tag, ".zero"},    {31'b0, o_zero},    {31'b0, m_zero});
    chk({tag, ".neg"},     {31'b0, o_neg},     {31'b0, m_neg});
    chk({tag, ".carry"},   {31'b0, o_carry},   {31'b0, m_carry});
    chk({tag, ".ovf"},     {31'b0, o_ovf},     {31'b0, m_ovf});
    chk({tag, ".illegal"}, {31'b0, o_illegal}, {31'b0, m_illegal});
  endtask

  vec_t vecs[13];
  logic [15:0] corner[6];

  initial begin
    // valid acc data op | e_valid e_res zero neg carry ovf illegal
    vecs[0]  = '{1, 16'h0001, 16'h0000, 5'b00100, 1, 16'h0001, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 16'h1111, 16'h2222, 5'b00100, 0, 16'h0001, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 16'h8000, 16'hFFFF, 5'b00100, 1, 16'h7FFF, 0, 0, 1, 1, 0};
    vecs[3]  = '{1, 16'h8000, 16'hFFFF, 5'b00101, 1, 16'h7FFF, 0, 0, 1, 1, 0};
    vecs[4]  = '{1, 16'h0006, 16'h0001, 5'b00101, 1, 16'h0007, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 16'h0100, 16'h0200, 5'b00000, 1, 16'h0007, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 16'h0000, 16'h0000, 5'b00100, 0, 16'h0007, 0, 0, 0, 0, 1};
    vecs[7]  = '{1, 16'h000F, 16'h0005, 5'b00110, 1, 16'h000A, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 16'h0030, 16'h8016, 5'b00111, 1, 16'h801A, 0, 1, 1, 1, 0};
    vecs[9]  = '{1, 16'h1234, 16'h1234, 5'b00110, 1, 16'h0000, 1, 0, 0, 0, 0};
    vecs[10] = '{1, 16'h0000, 16'h0001, 5'b00110, 1, 16'hFFFF, 0, 1, 1, 0, 0};
    vecs[11] = '{1, 16'h0005, 16'h0003, 5'b11111, 1, 16'hFFFF, 0, 1, 1, 0, 1};
    vecs[12] = '{1, 16'h0005, 16'h0003, 5'b10110, 1, 16'hFFFF, 0, 1, 1, 0, 1};
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

    apply(1, 0, 16'h0, 16'h0, 5'b0);
    apply(1, 0, 16'h0, 16'h0, 5'b0);
    chk("reset.valid",   {31'b0, o_valid},   32'd0);
    chk("reset.res",     {16'b0, o_RES},     32'd0);
    chk("reset.zero",    {31'b0, o_zero},    32'd0);
    chk("reset.illegal", {31'b0, o_illegal}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      apply(0, vecs[i].valid, vecs[i].acc, vecs[i].data, vecs[i].op);
      chk($sformatf("vec%0d.valid", i),   {31'b0, o_valid},   {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d.res", i),     {16'b0, o_RES},     {16'b0, vecs[i].e_res});
      chk($sformatf("vec%0d.zero", i),    {31'b0, o_zero},    {31'b0, vecs[i].e_zero});
      chk($sformatf("vec%0d.neg", i),     {31'b0, o_neg},     {31'b0, vecs[i].e_neg});
      chk($sformatf("vec%0d.carry", i),   {31'b0, o_carry},   {31'b0, vecs[i].e_carry});
      chk($sformatf("vec%0d.ovf", i),     {31'b0, o_ovf},     {31'b0, vecs[i].e_ovf});
      chk($sformatf("vec%0d.illegal", i), {31'b0, o_illegal}, {31'b0, vecs[i].e_illegal});
    end

    // Reset wins over a simultaneous valid ADD.
    apply(0, 1, 16'h8000, 16'h8000, 5'b00100);
    apply(1, 1, 16'h0001, 16'h0001, 5'b00100);
    chk("rst_prio.valid", {31'b0, o_valid}, 32'd0);
    chk("rst_prio.res",   {16'b0, o_RES},   32'd0);
    chk("rst_prio.carry", {31'b0, o_carry}, 32'd0);
    chk("rst_prio.ovf",   {31'b0, o_ovf},   32'd0);

    // Back-to-back ops: valid stays high, each result lands one cycle later.
    apply(0, 1, 16'h0010, 16'h0001, 5'b00100);
    chk("b2b0.res", {16'b0, o_RES}, 32'h0011);
    apply(0, 1, 16'h0010, 16'h0001, 5'b00110);
    chk("b2b1.valid", {31'b0, o_valid}, 32'd1);
    chk("b2b1.res",   {16'b0, o_RES},   32'h000F);
    apply(0, 1, 16'h7FFF, 16'h0001, 5'b00101);
    chk("b2b2.valid", {31'b0, o_valid}, 32'd1);
    chk("b2b2.res",   {16'b0, o_RES},   32'h8000);
    chk("b2b2.ovf",   {31'b0, o_ovf},   32'd1);
    apply(0, 0, 16'h0000, 16'h0000, 5'b00100);
    chk("b2b3.valid", {31'b0, o_valid}, 32'd0);
    chk("b2b3.res",   {16'b0, o_RES},   32'h8000);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        rv, rr;
      logic [15:0] ra, rd;
      logic [4:0]  rop;
      rr  = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rop = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(4, 7));
      apply(rr, rv, ra, rd, rop);
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
